// File: rtl/sail_write_commit_pkg.sv
// Shared sail library types: write record, byte unit, commit FSM states.
// Used by sail_write_commit and sail_write_fifo.
package sail_write_commit_pkg;

    localparam int SAIL_PADDR_W = 64;
    localparam int SAIL_UNIT_W  = 8;

    typedef logic [SAIL_UNIT_W-1:0]  sail_unit;
    typedef logic [SAIL_PADDR_W-1:0] sail_paddr_t;

    typedef struct packed {
        sail_paddr_t paddr;
        sail_unit    data;
    } sail_write;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } sail_wc_state_t;

    function automatic logic sail_addr_match(
        input sail_paddr_t a,
        input sail_paddr_t b
    );
        return a == b;
    endfunction

endpackage

// File: rtl/sail_write_fifo.sv
// Pending-write FIFO: storage, wrapping pointers with an extra lap bit,
// full/empty and occupancy. SAIL_WRITE_COMMIT_FWD_EN exposes the storage.
module sail_write_fifo
    import sail_write_commit_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  sail_write                  wdata,
    input  logic                       pop,
    output sail_write                  rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
`ifdef SAIL_WRITE_COMMIT_FWD_EN
    ,
    output sail_write                  entries [DEPTH],
    output logic [$clog2(DEPTH)-1:0]   head_idx
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    sail_write     mem_q [DEPTH];
    sail_write     mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

`ifdef SAIL_WRITE_COMMIT_FWD_EN
    assign entries  = mem_q;
    assign head_idx = rd_ptr_q[AW-1:0];
`endif

    // Next pointers and storage write for this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Pointer registers; reset discards every pending entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents beyond the pointers are never observed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sail_write_commit.sv
// Write-commit buffer: queues byte writes, retires them in order to memory,
// supports flush. SAIL_WRITE_COMMIT_FWD_EN adds youngest-match read forwarding.
module sail_write_commit
    import sail_write_commit_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [63:0]                wr_paddr,
    input  logic [7:0]                 wr_data,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [63:0]                mem_paddr,
    output logic [7:0]                 mem_data,
    input  logic                       flush,
    output logic                       flush_done,
    output logic [$clog2(DEPTH):0]     pending,
    output logic [CNT_W-1:0]           committed
`ifdef SAIL_WRITE_COMMIT_FWD_EN
    ,
    input  logic [63:0]                rd_paddr,
    output logic                       rd_hit,
    output logic [7:0]                 rd_data
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    sail_wc_state_t   state_q, state_d;
    logic [CNT_W-1:0] committed_q, committed_d;
    sail_write        wr_rec;
    sail_write        head_rec;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PW-1:0]    fifo_count;
    logic             accept;
    logic             retire;

`ifdef SAIL_WRITE_COMMIT_FWD_EN
    sail_write        fwd_entries [DEPTH];
    logic [AW-1:0]    fwd_head;
    logic [AW-1:0]    fwd_idx;
`endif

    assign wr_rec.paddr = wr_paddr;
    assign wr_rec.data  = wr_data;

    // Ready is held low while reset is asserted, even though state is RUN.
    assign wr_ready   = rst_n && !fifo_full && (state_q == RUN);
    assign mem_valid  = !fifo_empty;
    assign accept     = wr_valid && wr_ready;
    assign retire     = mem_valid && mem_ready;
    assign mem_paddr  = head_rec.paddr;
    assign mem_data   = head_rec.data;
    assign flush_done = (state_q == DONE);
    assign pending    = fifo_count;
    assign committed  = committed_q;

    sail_write_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (accept),
        .wdata    (wr_rec),
        .pop      (retire),
        .rdata    (head_rec),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
`ifdef SAIL_WRITE_COMMIT_FWD_EN
        ,
        .entries  (fwd_entries),
        .head_idx (fwd_head)
`endif
    );

    // Flush FSM next state and retire counter.
    always_comb begin
        state_d     = state_q;
        committed_d = committed_q;
        if (retire) begin
            committed_d = committed_q + CNT_W'(1);
        end
        unique case (state_q)
            RUN: begin
                if (flush) state_d = FLUSH;
            end
            FLUSH: begin
                if (fifo_empty) state_d = DONE;
            end
            DONE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            committed_q <= '0;
        end else begin
            state_q     <= state_d;
            committed_q <= committed_d;
        end
    end

`ifdef SAIL_WRITE_COMMIT_FWD_EN
    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = fwd_head + AW'(i);
            if ((PW'(i) < fifo_count) &&
                sail_addr_match(fwd_entries[fwd_idx].paddr, rd_paddr)) begin
                rd_hit  = 1'b1;
                rd_data = fwd_entries[fwd_idx].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sail_write_commit.sv
// Directed self-checking bench for sail_write_commit.
// Second instance with CNT_W=4 checks counter wrap.
module tb_sail_write_commit;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_paddr;
    logic [7:0]  wr_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [63:0] mem_paddr;
    logic [7:0]  mem_data;
    logic        flush;
    logic        flush_done;
    logic [3:0]  pending;
    logic [31:0] committed;

    logic        c_wr_valid;
    logic        c_wr_ready;
    logic [63:0] c_wr_paddr;
    logic [7:0]  c_wr_data;
    logic        c_mem_valid;
    logic        c_mem_ready;
    logic [63:0] c_mem_paddr;
    logic [7:0]  c_mem_data;
    logic        c_flush;
    logic        c_flush_done;
    logic [3:0]  c_pending;
    logic [3:0]  c_committed;

`ifdef SAIL_WRITE_COMMIT_FWD_EN
    logic [63:0] rd_paddr;
    logic        rd_hit;
    logic [7:0]  rd_data;
    logic [63:0] c_rd_paddr;
    logic        c_rd_hit;
    logic [7:0]  c_rd_data;
`endif

    int passed;
    int failed;
    int total;

    logic [63:0] log_a[$];
    logic [7:0]  log_d[$];
    logic [63:0] exp_a[$];
    logic [7:0]  exp_d[$];

    sail_write_commit #(.DEPTH(8), .CNT_W(32)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_paddr   (wr_paddr),
        .wr_data    (wr_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_paddr  (mem_paddr),
        .mem_data   (mem_data),
        .flush      (flush),
        .flush_done (flush_done),
        .pending    (pending),
        .committed  (committed)
`ifdef SAIL_WRITE_COMMIT_FWD_EN
        ,
        .rd_paddr   (rd_paddr),
        .rd_hit     (rd_hit),
        .rd_data    (rd_data)
`endif
    );

    sail_write_commit #(.DEPTH(8), .CNT_W(4)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (c_wr_valid),
        .wr_ready   (c_wr_ready),
        .wr_paddr   (c_wr_paddr),
        .wr_data    (c_wr_data),
        .mem_valid  (c_mem_valid),
        .mem_ready  (c_mem_ready),
        .mem_paddr  (c_mem_paddr),
        .mem_data   (c_mem_data),
        .flush      (c_flush),
        .flush_done (c_flush_done),
        .pending    (c_pending),
        .committed  (c_committed)
`ifdef SAIL_WRITE_COMMIT_FWD_EN
        ,
        .rd_paddr   (c_rd_paddr),
        .rd_hit     (c_rd_hit),
        .rd_data    (c_rd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side log of every retired write.
    always @(posedge clk) begin
        if (rst_n && mem_valid && mem_ready) begin
            log_a.push_back(mem_paddr);
            log_d.push_back(mem_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [63:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_paddr = a;
        wr_data  = d;
    endtask

    initial begin : stim
        int zc;
        int dc;
        int pulses;
        int bad_ready;
        passed = 0;
        failed = 0;
        total  = 0;
        rst_n = 1'b0;
        wr_valid = 1'b0;
        wr_paddr = '0;
        wr_data = '0;
        mem_ready = 1'b0;
        flush = 1'b0;
        c_wr_valid = 1'b0;
        c_wr_paddr = '0;
        c_wr_data = '0;
        c_mem_ready = 1'b0;
        c_flush = 1'b0;
`ifdef SAIL_WRITE_COMMIT_FWD_EN
        rd_paddr = '0;
        c_rd_paddr = '0;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_committed", 64'(committed), 64'd0);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_wr_ready", 64'(wr_ready), 64'd1);

        // Three in-order writes with memory always ready
        mem_ready = 1'b1;
        put(64'h1000, 8'hAA);
        exp_a.push_back(64'h1000); exp_d.push_back(8'hAA);
        #1;
        chk("no_bypass", 64'(mem_valid), 64'd0);
        tick();
        chk("lat1_valid", 64'(mem_valid), 64'd1);
        chk("lat1_paddr", mem_paddr, 64'h1000);
        put(64'h1001, 8'hBB);
        exp_a.push_back(64'h1001); exp_d.push_back(8'hBB);
        tick();
        put(64'h1000, 8'hCC);
        exp_a.push_back(64'h1000); exp_d.push_back(8'hCC);
        tick();
        wr_valid = 1'b0;
        repeat (3) tick();
        chk("seq_pending", 64'(pending), 64'd0);
        chk("seq_committed", committed, 64'd3);
        chk("seq_log_size", 64'(log_a.size()), 64'd3);

        // Fill to full with memory stalled; ninth offer is refused
        mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            put(64'h3000 + 64'(i), 8'(i));
            if (i < 8) begin
                exp_a.push_back(64'h3000 + 64'(i));
                exp_d.push_back(8'(i));
            end
            tick();
        end
        chk("full_pending", 64'(pending), 64'd8);
        chk("full_wr_ready", 64'(wr_ready), 64'd0);
        chk("stall_paddr", mem_paddr, 64'h3000);
        chk("stall_data", 64'(mem_data), 64'h0);

        // Retire while full: slot frees next cycle, ready low this cycle
        put(64'h3100, 8'h5A);
        mem_ready = 1'b1;
        #1;
        chk("full_retire_ready", 64'(wr_ready), 64'd0);
        tick();
        chk("after_retire_pend", 64'(pending), 64'd7);
        chk("after_retire_head", mem_paddr, 64'h3001);
        exp_a.push_back(64'h3100); exp_d.push_back(8'h5A);
        tick();
        chk("acc_ret_pending", 64'(pending), 64'd7);
        chk("acc_ret_head", mem_paddr, 64'h3002);
        wr_valid = 1'b0;
        repeat (3) tick();
        mem_ready = 1'b0;
        chk("pre_flush_pend", 64'(pending), 64'd4);

        // Flush with 4 pending and a toggling memory ready
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_wr_ready", 64'(wr_ready), 64'd0);
        zc = -1;
        dc = -1;
        pulses = 0;
        bad_ready = 0;
        for (int c = 0; c < 40; c++) begin
            mem_ready = (c % 2) == 1;
            tick();
            if (flush_done) begin
                pulses++;
                if (dc < 0) dc = c;
            end
            if ((dc < 0 || flush_done) && wr_ready) bad_ready++;
            if (pending == 0 && zc < 0) zc = c;
        end
        mem_ready = 1'b0;
        chk("flush_pulses", 64'(pulses), 64'd1);
        chk("flush_done_timing", 64'(dc), 64'(zc + 1));
        chk("flush_ready_low", 64'(bad_ready), 64'd0);
        chk("flush_committed", committed, 64'd12);
        chk("back_to_run", 64'(wr_ready), 64'd1);
        chk("log_size", 64'(log_a.size()), 64'd12);
        for (int k = 0; k < 12; k++) begin
            if (k < log_a.size()) begin
                chk($sformatf("order_a%0d", k), log_a[k], exp_a[k]);
                chk($sformatf("order_d%0d", k), 64'(log_d[k]), 64'(exp_d[k]));
            end
        end

        // Flush with an empty FIFO reaches DONE after two edges
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("eflush_1", 64'(flush_done), 64'd0);
        tick();
        chk("eflush_2", 64'(flush_done), 64'd1);
        chk("eflush_ready", 64'(wr_ready), 64'd0);
        tick();
        chk("eflush_3", 64'(flush_done), 64'd0);
        chk("eflush_run", 64'(wr_ready), 64'd1);

        // Reset in the middle of operation with 5 pending
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            put(64'h4000 + 64'(i), 8'(8'h40 + i));
            tick();
        end
        wr_valid = 1'b0;
        chk("mid_pending", 64'(pending), 64'd5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(mem_valid), 64'd0);
        chk("mid_rst_pending", 64'(pending), 64'd0);
        chk("mid_rst_committed", committed, 64'd0);
        chk("mid_rst_ready", 64'(wr_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        repeat (4) tick();
        chk("no_stale_valid", 64'(mem_valid), 64'd0);
        chk("no_stale_log", 64'(log_a.size()), 64'd12);

        // Narrow counter wraps: 17 retires leaves 1
        c_mem_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            c_wr_valid = 1'b1;
            c_wr_paddr = 64'h5000 + 64'(i);
            c_wr_data = 8'(i);
            tick();
        end
        c_wr_valid = 1'b0;
        repeat (3) tick();
        chk("cnt_wrap", 64'(c_committed), 64'd1);
        chk("cnt_pending", 64'(c_pending), 64'd0);

`ifdef SAIL_WRITE_COMMIT_FWD_EN
        // Forwarding returns the youngest matching entry
        mem_ready = 1'b0;
        put(64'h2000, 8'h11);
        tick();
        put(64'h2000, 8'h22);
        tick();
        wr_valid = 1'b0;
        rd_paddr = 64'h2000;
        #1;
        chk("fwd_hit", 64'(rd_hit), 64'd1);
        chk("fwd_data", 64'(rd_data), 64'h22);
        rd_paddr = 64'h2001;
        #1;
        chk("fwd_miss", 64'(rd_hit), 64'd0);
        chk("fwd_miss_data", 64'(rd_data), 64'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
